// File: rtl/gene_pkg.sv
// Shared constants and slot helpers for the gene base packer.
package gene_pkg;
  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  localparam int BASES_PER_WORD = 4;
  localparam int WORD_W         = 8;

  // ui_in bit positions
  localparam int UI_CODE_LO = 0;
  localparam int UI_BASE    = 2;
  localparam int UI_FLUSH   = 3;
  localparam int UI_ACK     = 4;
  localparam int UI_OCLR    = 5;

  // uio_out bit positions
  localparam int UO_VALID   = 0;
  localparam int UO_READY   = 1;
  localparam int UO_FILL_LO = 2;
  localparam int UO_OVF     = 4;
  localparam int UO_FULL    = 5;

  function automatic logic [WORD_W-1:0] set_slot(input logic [WORD_W-1:0] w,
                                                 input logic [1:0] idx,
                                                 input logic [1:0] code);
    logic [WORD_W-1:0] r;
    r = w;
    r[2*idx +: 2] = code;
    return r;
  endfunction

  // Fill every slot from 'from' upward with the pad code.
  function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] w,
                                                 input logic [1:0] from,
                                                 input logic [1:0] pad);
    logic [WORD_W-1:0] r;
    r = w;
    for (int i = 0; i < BASES_PER_WORD; i++)
      if (2'(i) >= from) r[2*i +: 2] = pad;
    return r;
  endfunction
endpackage

// File: rtl/gene_word_fifo.sv
// Small word FIFO; a pop frees room for a same-cycle push when full.
module gene_word_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/gene_base_packer.sv
// Packs strobed 2-bit DNA bases into bytes, buffers them and hands them out
// over a valid/ack strobe handshake in a TinyTapeout slot.
module gene_base_packer
  import gene_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter int         FIFO_DEPTH  = 2,
  parameter logic [1:0] PAD_BASE    = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]        synced;
  logic [3:0]        strb_q, pulse;
  logic              base_p, flush_p, ack_p, oclr_p;
  logic [1:0]        fill, fill_b;
  logic [WORD_W-1:0] slots, word_b, push_word, head;
  logic              complete, flush_go, push_req, pop, drop, overflow;
  logic              fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      strb_q <= '0;
    end else begin
      sync_q[0] <= ui_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      strb_q <= synced[UI_OCLR:UI_BASE];
    end
  end

  assign synced  = sync_q[SYNC_STAGES-1];
  assign pulse   = synced[UI_OCLR:UI_BASE] & ~strb_q;
  assign base_p  = pulse[0];
  assign flush_p = pulse[1];
  assign ack_p   = pulse[2];
  assign oclr_p  = pulse[3];

  // Base is applied first; flush then sees the post-base fill, so a flush
  // coinciding with a completing base finds fill==0 and does nothing.
  always_comb begin
    word_b    = base_p ? set_slot(slots, fill, synced[UI_CODE_LO +: 2]) : slots;
    complete  = base_p && (fill == 2'd3);
    fill_b    = complete ? 2'd0 : fill + 2'(base_p);
    flush_go  = flush_p && (fill_b != 2'd0);
    push_req  = complete || flush_go;
    push_word = complete ? word_b : pad_word(word_b, fill_b, PAD_BASE);
    pop       = ack_p && !fifo_empty;
    drop      = push_req && fifo_full && !pop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill     <= '0;
      slots    <= '0;
      overflow <= 1'b0;
    end else begin
      fill     <= push_req ? 2'd0 : fill_b;
      slots    <= word_b;
      overflow <= drop ? 1'b1 : (oclr_p ? 1'b0 : overflow);
    end
  end

  gene_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req && !drop),
    .din   (push_word),
    .pop   (pop),
    .head  (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_comb begin
    uio_out                        = '0;
    uio_out[UO_VALID]              = !fifo_empty;
    uio_out[UO_READY]              = !(fifo_full && fill == 2'd3);
    uio_out[UO_FILL_LO +: 2]       = fill;
    uio_out[UO_OVF]                = overflow;
    uio_out[UO_FULL]               = fifo_full;
  end

  assign uo_out = fifo_empty ? 8'h00 : head;
  assign uio_oe = 8'b0011_1111;

  logic unused_ok;
  assign unused_ok = ^{ena, uio_in, synced[7:6], fifo_count};
endmodule

// File: tb/tb_gene_base_packer.sv
// Randomized and directed checks of gene_base_packer against a queue model.
module tb_gene_base_packer;
  localparam int         DEPTH = 2;
  localparam logic [1:0] PAD   = 2'b00;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       ena = 1;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int total = 0;
  int bad   = 0;
  bit ack_hold = 0;

  // reference model state
  logic [7:0] q[$];
  logic [1:0] part[$];
  bit         m_ovf;

  always #5 clk = ~clk;

  gene_base_packer #(.SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .PAD_BASE(PAD)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  function automatic void m_reset();
    q.delete(); part.delete(); m_ovf = 0;
  endfunction

  function automatic void m_apply(bit b, logic [1:0] code, bit f, bit a, bit c);
    logic [7:0] w;
    bit have, setov, popv;
    have = 0; setov = 0; w = '0;
    popv = a && (q.size() > 0);
    if (b) begin
      part.push_back(code);
      if (part.size() == 4) have = 1;
    end
    if (f && !have && part.size() > 0) begin
      while (part.size() < 4) part.push_back(PAD);
      have = 1;
    end
    if (have) begin
      for (int i = 0; i < 4; i++) w = w | (8'(part[i]) << (2*i));
      part.delete();
    end
    if (popv) void'(q.pop_front());
    if (have) begin
      if (q.size() < DEPTH) q.push_back(w);
      else setov = 1;
    end
    if (setov) m_ovf = 1;
    else if (c) m_ovf = 0;
  endfunction

  function automatic logic [7:0] m_uo();
    return (q.size() > 0) ? q[0] : 8'h00;
  endfunction

  function automatic logic [7:0] m_uio();
    bit full;
    logic [1:0] fl;
    full = (q.size() == DEPTH);
    fl = 2'(part.size());
    return {2'b00, full, m_ovf, fl, !(full && part.size() == 3), q.size() != 0};
  endfunction

  // One strobe event at the pins; all chosen strobes rise on the same clk.
  task automatic ev(bit b, logic [1:0] code, bit f, bit a, bit c);
    logic [7:0] idle;
    idle = {2'b00, 1'b0, ack_hold, 2'b00, code};
    @(negedge clk) ui_in = idle;
    @(negedge clk) ui_in = idle | {2'b00, c, a, f, b, 2'b00};
    repeat (3) @(negedge clk);
    ui_in = idle;
    repeat (4) @(negedge clk);
    m_apply(b, code, f, a && !ack_hold, c);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 0;
    ui_in = {3'b000, ack_hold, 4'b0000};
    repeat (3) @(negedge clk);
    rst_n = 1;
    m_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_uo got %h want 00", uo_out); end
    total++; if (uio_out !== 8'h02) begin bad++; $display("FAIL reset_uio got %h want 02", uio_out); end
    total++; if (uio_oe !== 8'h3F) begin bad++; $display("FAIL uio_oe got %h want 3f", uio_oe); end
  endtask

  task automatic test_full_word();
    ev(1, 2'b00, 0, 0, 0); ev(1, 2'b01, 0, 0, 0); ev(1, 2'b10, 0, 0, 0); ev(1, 2'b11, 0, 0, 0);
    total++; if (uo_out !== 8'hE4) begin bad++; $display("FAIL word_acgt got %h want e4", uo_out); end
    total++; if (uio_out !== m_uio()) begin bad++; $display("FAIL word_acgt_status got %h want %h", uio_out, m_uio()); end
    ev(0, 2'b00, 0, 1, 0);
    total++; if (uo_out !== 8'h00) begin bad++; $display("FAIL ack_empty got %h want 00", uo_out); end
    total++; if (uio_out !== m_uio()) begin bad++; $display("FAIL ack_status got %h want %h", uio_out, m_uio()); end
  endtask

  task automatic test_flush();
    ev(1, 2'b10, 0, 0, 0); ev(1, 2'b11, 0, 0, 0); ev(0, 2'b00, 1, 0, 0);
    total++; if (uo_out !== 8'h0E) begin bad++; $display("FAIL flush_gt got %h want 0e", uo_out); end
    ev(0, 2'b00, 1, 0, 0);
    total++; if (uio_out !== m_uio()) begin bad++; $display("FAIL flush_noop got %h want %h", uio_out, m_uio()); end
    ev(0, 2'b00, 0, 1, 0);
    total++; if (uio_out[0] !== 1'b0) begin bad++; $display("FAIL flush_single_word valid got %b want 0", uio_out[0]); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 11; i++) ev(1, 2'(i), 0, 0, 0);
    total++; if (uio_out !== m_uio()) begin bad++; $display("FAIL ready_drop got %h want %h", uio_out, m_uio()); end
    total++; if (uio_out[1] !== 1'b0) begin bad++; $display("FAIL ready_low got %b want 0", uio_out[1]); end
    ev(1, 2'b11, 0, 0, 0);
    total++; if (uio_out[4] !== 1'b1) begin bad++; $display("FAIL ovf_set got %b want 1", uio_out[4]); end
    total++; if (uo_out !== 8'hE4) begin bad++; $display("FAIL ovf_head got %h want e4", uo_out); end
    ev(0, 2'b00, 0, 1, 0);
    total++; if (uo_out !== 8'hE4) begin bad++; $display("FAIL drain2 got %h want e4", uo_out); end
    ev(0, 2'b00, 0, 1, 0);
    total++; if (uio_out !== m_uio()) begin bad++; $display("FAIL drained got %h want %h", uio_out, m_uio()); end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 3; i++) ev(1, 2'b01, 0, 0, 0);
    ev(1, 2'b10, 1, 0, 0);
    total++; if (uo_out !== 8'h95 || uio_out !== m_uio()) begin bad++; $display("FAIL base_flush_fill3 got %h/%h want 95/%h", uo_out, uio_out, m_uio()); end
    ev(1, 2'b11, 0, 0, 0);
    ev(1, 2'b10, 1, 0, 0);
    total++; if (uio_out !== m_uio()) begin bad++; $display("FAIL base_flush_fill1 got %h want %h", uio_out, m_uio()); end
    ev(0, 2'b00, 0, 1, 0);
    total++; if (uo_out !== 8'h0B) begin bad++; $display("FAIL pad_word got %h want 0b", uo_out); end
  endtask

  task automatic test_ack_push_full();
    // FIFO holds one word (0B); add one more to fill, then overflow and clear.
    for (int i = 0; i < 4; i++) ev(1, 2'b10, 0, 0, 0);
    for (int i = 0; i < 4; i++) ev(1, 2'b00, 0, 0, 0);
    ev(0, 2'b00, 0, 0, 1);
    total++; if (uio_out[4] !== 1'b0 || uio_out !== m_uio()) begin bad++; $display("FAIL ovf_clear got %h want %h", uio_out, m_uio()); end
    for (int i = 0; i < 3; i++) ev(1, 2'b01, 0, 0, 0);
    ev(1, 2'b11, 0, 1, 0);
    total++; if (uio_out !== m_uio() || uio_out[5] !== 1'b1 || uio_out[4] !== 1'b0) begin bad++; $display("FAIL ack_push_full got %h want %h", uio_out, m_uio()); end
    total++; if (uo_out !== 8'hAA) begin bad++; $display("FAIL ack_push_head got %h want aa", uo_out); end
    ev(0, 2'b00, 0, 1, 0);
    total++; if (uo_out !== 8'hD5) begin bad++; $display("FAIL ack_push_tail got %h want d5", uo_out); end
  endtask

  task automatic test_reset_mid_word();
    ev(1, 2'b11, 0, 0, 0); ev(1, 2'b10, 0, 0, 0);
    ack_hold = 1;
    ev(0, 2'b00, 0, 1, 0);
    m_apply(0, 2'b00, 0, 1, 0);
    @(negedge clk) rst_n = 0;
    #1;
    total++; if (uo_out !== 8'h00 || uio_out !== 8'h02) begin bad++; $display("FAIL async_reset got %h/%h want 00/02", uo_out, uio_out); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_reset();
    repeat (6) @(negedge clk);
    total++; if (uio_out !== 8'h02) begin bad++; $display("FAIL post_reset_held got %h want 02", uio_out); end
    for (int i = 0; i < 4; i++) ev(1, 2'(3 - i), 0, 0, 0);
    total++; if (uo_out !== 8'h1B || uio_out[0] !== 1'b1) begin bad++; $display("FAIL held_ack_no_pop got %h/%b want 1b/1", uo_out, uio_out[0]); end
    ack_hold = 0;
    ev(0, 2'b00, 0, 0, 0);
    total++; if (uio_out !== m_uio()) begin bad++; $display("FAIL ack_release got %h want %h", uio_out, m_uio()); end
  endtask

  task automatic test_random();
    bit b, f, a, c;
    logic [1:0] code;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      b = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) < 2);
      a = ($urandom_range(0, 9) < 3);
      c = ($urandom_range(0, 9) < 1);
      code = 2'($urandom);
      ev(b, code, f, a, c);
      total++; if (uo_out !== m_uo()) begin bad++; $display("FAIL rand_uo[%0d] got %h want %h", n, uo_out, m_uo()); end
      total++; if (uio_out !== m_uio()) begin bad++; $display("FAIL rand_uio[%0d] got %h want %h", n, uio_out, m_uio()); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_full_word();
    test_flush();
    test_reset();
    test_overflow();
    test_same_cycle();
    test_ack_push_full();
    test_reset();
    test_reset_mid_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
